// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and payload types for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a target address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush.
// The head entry resets to RESET_ENTRY so decode sees a NOP at the reset PC.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned  DEPTH       = 2,
    parameter fetch_entry_t RESET_ENTRY = '{pc: RESET_PC_DEFAULT, instr: NOP_INSTR}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage and pointer update; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= RESET_ENTRY;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full));
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, credit-limited memory reads,
// response buffering and redirect flush.
// Optional macro FETCH_BYPASS_EN: forward a response straight to decode
// when nothing is buffered (zero-cycle response-to-decode latency).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc,          pc_n;
    logic [31:0]   resp_pc,     resp_pc_n;
    logic [CW-1:0] outstanding, outstanding_n;
    logic [CW-1:0] drop,        drop_n;

    logic          fire;
    logic          keep;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    fetch_entry_t  fifo_head;
    fetch_entry_t  resp_entry;

    // Credit check counts words in flight plus words already buffered.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req    = !redirect && (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr   = pc;
    assign fire        = imem_req && imem_gnt;
    assign keep        = imem_rvalid && !redirect && (drop == '0);
    assign resp_entry  = '{pc: resp_pc, instr: imem_rdata};
    assign fifo_pop    = !fifo_empty && instr_ready && !redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = keep && fifo_empty;
    assign instr_valid = !fifo_empty || bypass;
    assign instr       = bypass ? imem_rdata : fifo_head.instr;
    assign instr_pc    = bypass ? resp_pc    : fifo_head.pc;
    assign fifo_push   = keep && !(bypass && instr_ready);
`else
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign fifo_push   = keep;
`endif

    // Next-state for PCs and the in-flight / discard counters; redirect wins.
    always_comb begin
        pc_n          = pc;
        resp_pc_n     = resp_pc;
        outstanding_n = outstanding;
        drop_n        = drop;
        if (redirect) begin
            pc_n          = align_pc(redirect_pc);
            resp_pc_n     = align_pc(redirect_pc);
            outstanding_n = outstanding - CW'(imem_rvalid);
            drop_n        = outstanding - CW'(imem_rvalid);
        end else begin
            if (fire) begin
                pc_n = pc + PC_INCR;
            end
            if (keep) begin
                resp_pc_n = resp_pc + PC_INCR;
            end
            outstanding_n = outstanding + CW'(fire) - CW'(imem_rvalid);
            if (imem_rvalid && (drop != '0)) begin
                drop_n = drop - CW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (imem_rvalid) begin
                assert (outstanding != '0);
            end
            pc          <= pc_n;
            resp_pc     <= resp_pc_n;
            outstanding <= outstanding_n;
            drop        <= drop_n;
        end
    end

    instr_fetch_unit_fifo #(
        .DEPTH       (FIFO_DEPTH),
        .RESET_ENTRY ('{pc: RESET_PC, instr: NOP_INSTR})
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized grants, latencies, stalls and redirects against a queue model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory model: in-order responses tagged with the fetch epoch they belong to.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          rc;
    } rsp_t;

    rsp_t        mq[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];
    logic [31:0] gnt_log[$];

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          buffered = 0;
    int          epoch = 0;
    int          grants = 0;
    int          last_rc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] fetch_pc = RESET_PC;
    logic [31:0] dec_pc = RESET_PC;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mq.delete();
        buffered = 0;
        epoch++;
        fetch_pc = RESET_PC;
        dec_pc   = RESET_PC;
        last_rc  = 0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, RESET_PC);
        chk("rst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit gnt_i, input bit ready_i, input bit redir_i, input logic [31:0] rpc_i);
        bit rsp, stale, byp, exp_req, exp_valid, fire, pop;
        int lat, rc;
        @(negedge clk);
        cyc++;
        imem_gnt    = gnt_i;
        instr_ready = ready_i;
        redirect    = redir_i;
        redirect_pc = rpc_i;
        rsp         = (mq.size() > 0) && (mq[0].rc <= cyc);
        imem_rvalid = rsp;
        imem_rdata  = rsp ? memf(mq[0].addr) : $urandom;
        #1;
        stale     = rsp && (mq[0].epoch != epoch);
        exp_req   = !redir_i && ((mq.size() + buffered) < DEPTH);
        byp       = BYP && rsp && !stale && !redir_i && (buffered == 0);
        exp_valid = (buffered > 0) || byp;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, fetch_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("instr_pc", instr_pc, dec_pc);
            chk("instr", instr, memf(dec_pc));
        end
        fire = exp_req && gnt_i;
        pop  = exp_valid && ready_i;
        if (rsp) void'(mq.pop_front());
        if (redir_i) begin
            epoch++;
            buffered = 0;
            fetch_pc = rpc_i & ~32'd3;
            dec_pc   = rpc_i & ~32'd3;
        end else begin
            if (fire) begin
                lat = $urandom_range(lat_max, lat_min);
                rc  = cyc + lat;
                if (rc <= last_rc) rc = last_rc + 1;
                last_rc = rc;
                mq.push_back('{addr: fetch_pc, epoch: epoch, rc: rc});
                gnt_log.push_back(imem_addr);
                grants++;
                fetch_pc = fetch_pc + 32'd4;
            end
            if (rsp && !stale) buffered++;
            if (pop) begin
                pop_pc.push_back(instr_pc);
                pop_cyc.push_back(cyc);
                buffered--;
                dec_pc = dec_pc + 32'd4;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  p0, g0, idx;
        bit  found;

        // Reset state, then streaming fetch with 1-cycle memory.
        do_reset();
        lat_min = 1; lat_max = 1;
        p0 = pop_pc.size();
        for (int i = 0; i < 6; i++) step(1, 1, 0, '0);
        chk("stream_pop0", (pop_pc.size() > p0) ? pop_pc[p0] : 32'hDEAD_BEEF, 32'h0);
        chk("stream_pop1", (pop_pc.size() > p0 + 1) ? pop_pc[p0+1] : 32'hDEAD_BEEF, 32'h4);
        chk("stream_consec", (pop_cyc.size() > p0 + 1) ? 32'(pop_cyc[p0+1] - pop_cyc[p0]) : 32'hFFFF, 32'd1);

        // Decode stalled: only FIFO_DEPTH requests go out, head holds.
        do_reset();
        g0 = grants;
        for (int i = 0; i < 10; i++) step(1, 0, 0, '0);
        chk("stall_grants", 32'(grants - g0), 32'(DEPTH));
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_pc", instr_pc, 32'h0);
        chk("stall_instr", instr, 32'h0050_0093);

        // Redirect with two reads outstanding: both stale words dropped.
        do_reset();
        lat_min = 5; lat_max = 5;
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        chk("redir_outstanding", 32'(mq.size()), 32'd2);
        step(0, 0, 1, 32'h0000_0103);
        step(0, 0, 0, '0);
        chk("redir_addr", imem_addr, 32'h100);
        idx = pop_pc.size();
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 20; i++) step(1, 1, 0, '0);
        chk("redir_first_pc", (pop_pc.size() > idx) ? pop_pc[idx] : 32'hDEAD_BEEF, 32'h100);

        // Redirect coinciding with a response and a pop.
        do_reset();
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, '0);
            found = (mq.size() > 0) && (mq[0].rc == cyc + 1) && (buffered > 0);
        end
        chk("coincide_setup", 32'(found), 32'd1);
        step(0, 1, 1, 32'h0000_0200);
        step(0, 0, 0, '0);
        chk("coincide_empty", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, '0);

        // Redirect to the top word: fetch wraps to zero.
        do_reset();
        step(0, 1, 1, 32'hFFFF_FFFC);
        gnt_log.delete();
        for (int i = 0; i < 6; i++) step(1, 1, 0, '0);
        chk("wrap_first", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_second", (gnt_log.size() > 1) ? gnt_log[1] : 32'hDEAD_BEEF, 32'h0);

        // Response-to-decode latency with an empty FIFO.
        do_reset();
        lat_min = 2; lat_max = 2;
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("lat_resp_cycle", 32'(instr_valid), 32'(BYP));
        step(0, 0, 0, '0);
        chk("lat_next_cycle", 32'(instr_valid), 32'd1);
        chk("lat_instr", instr, 32'h0050_0093);

        // Randomized traffic with a reset in the middle.
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            step(($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 6),
                 ($urandom_range(99, 0) < 4), $urandom);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of instruction decode and the immediate generator.
- Holds the PC and issues in-order word reads to instruction memory.
- Buffers returned words in a small FIFO and presents {instr, instr_pc} to decode with a valid/ready handshake.
- Accepts a redirect from the branch/jump unit, flushing buffered and in-flight words.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address.
- imem_gnt  in  1  request accepted this cycle (when imem_req=1).
- imem_rvalid  in  1  read data valid; responses return in order, 1 or more cycles after grant.
- imem_rdata  in  32  instruction word.
- redirect  in  1  one-cycle PC redirect (taken branch, JAL, JALR).
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr  out  32  instruction word to decode and the immediate generator.
- instr_pc  out  32  address of instr.
- instr_ready  in  1  decode accepts the current word.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - rst_n is asynchronous and active-low.
  - Reset values: pc=RESET_PC, FIFO empty, outstanding=0, drop=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC.
  - imem_req may assert in the first clk edge window after rst_n deasserts.
- Credit rule:
  - imem_req = !redirect && (outstanding + fifo_count < FIFO_DEPTH).
  - imem_addr = pc.
  - Handshake completes when imem_req && imem_gnt. On completion: pc += 4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), outstanding += 1.
  - While imem_req=1 and imem_gnt=0, imem_addr stays stable.
- Response:
  - When imem_rvalid=1: outstanding -= 1.
  - If drop>0: the word is discarded and drop -= 1.
  - Otherwise the word is pushed into the FIFO, tagged with its PC. The tag comes from a separate response-PC counter, which advances by 4 on each accepted response.
  - The credit rule guarantees the FIFO never overflows. Push while full is an assertion failure.
- Decode side:
  - instr_valid = FIFO not empty. instr/instr_pc come from the FIFO head.
  - The head pops when instr_valid && instr_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - When instr_valid=1, instr and instr_pc hold stable until popped.
- Latency (no bypass): a response in cycle N gives instr_valid=1 in cycle N+1.
- Redirect (takes priority over all other events in the same cycle):
  - FIFO cleared; instr_valid=0 next cycle.
  - pc and the response-PC counter load {redirect_pc[31:2], 2'b00}.
  - drop <= outstanding minus any response retiring in that cycle. A same-cycle response is discarded.
  - imem_req=0 in the redirect cycle; a pending ungranted request is abandoned.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Counter widths: outstanding and drop are $clog2(FIFO_DEPTH)+1 bits. Neither may underflow; an rvalid with outstanding=0 is an assertion failure.
- Reset mid-operation: all state returns to reset values immediately. Memory responses arriving after reset must be preceded by memory reset; none are dropped.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop=0, no redirect and imem_rvalid=1, imem_rdata and its PC drive instr/instr_pc combinationally with instr_valid=1 in the same cycle. If instr_ready=1 the word is consumed without a push; otherwise it is pushed. Zero-cycle response-to-decode latency.
- Undefined: all responses are registered through the FIFO; latency is 1 cycle.

Decomposition:
- Shared package / common_library.vh holds: NOP_INSTR=32'h0000_0013, RESET_PC default, and PC_INCR=4.
- Natural sub-module: fetch_fifo, a parametric synchronous FIFO of {pc[31:0], instr[31:0]} with push/pop/full/empty/count and flush.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle response returning 0x00500093 at 0x0 and 0x00A00113 at 0x4, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8...; decode sees (0x0, 0x00500093) then (0x4, 0x00A00113) on consecutive cycles.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) requests issued, then imem_req=0; instr/instr_pc stay stable at PC 0x0.
- Redirect to 0x0000_0103 with 2 reads outstanding -> next imem_addr=0x100; both stale responses discarded; first decoded instr_pc=0x100.
- Redirect in the same cycle as rvalid and a pop -> stale word never appears on instr; FIFO empty next cycle.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).
- With FETCH_BYPASS_EN, FIFO empty, response at cycle N -> instr_valid=1 in cycle N with instr=imem_rdata. Without the macro -> instr_valid=1 in cycle N+1.
